// File: rtl/psum_pkg.sv
// Shared constants for the kernel psum collector: lane width, err_psum bit map, FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package psum_pkg;

  // Lane width for the default BIT_WIDTH of 8; modules derive their own via psum_width().
  localparam int PSUM_WIDTH = 16;

  // err_psum bit positions
  localparam int ERR_VLD_MISMATCH = 0;
  localparam int ERR_OVERFLOW     = 1;
  localparam int ERR_UNDERFLOW    = 2;
  localparam int ERR_DROP_LSB     = 16;
  localparam int DROP_CNT_WIDTH   = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // A psum lane holds a full product of two BIT_WIDTH operands.
  function automatic int psum_width(input int bit_width);
    return 2 * bit_width;
  endfunction

endpackage

// File: rtl/psum_sync_fifo.sv
// Synchronous FIFO, parameterised width/depth, head data visible combinationally.
// Latency: a push becomes visible at the head on the cycle after it is written.
// Backpressure: push refused when full unless a pop happens in the same cycle.
module psum_sync_fifo #(
  parameter int W  = 64,
  parameter int D  = 16,
  parameter int CW = $clog2(D) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_dat,
  output logic [W-1:0]  o_dat,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = $clog2(D);

  logic [W-1:0]  r_mem [D];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(D));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dat   = r_mem[r_rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  // Storage array; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_dat;
  end

  // Pointers wrap naturally because D is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/kernel_psum_collector.sv
// Collects NUM_KERNEL psum lanes per entry into a FIFO and serialises them kernel 0 first.
// Latency: push at cycle t into an empty idle block -> first beat valid at t+2; 1 beat/cycle steady state.
// Backpressure: outputs hold while i_data_rdy=0; full FIFO drops pushes (counted). Macro PSUM_RELU_EN clamps negative lanes to 0.
module kernel_psum_collector
  import psum_pkg::*;
#(
  parameter int BIT_WIDTH  = 8,
  parameter int NUM_KERNEL = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int REG_WIDTH  = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [2*BIT_WIDTH*NUM_KERNEL-1:0] i_psum,
  input  logic [NUM_KERNEL-1:0]             i_psum_vld,
  output logic [2*BIT_WIDTH-1:0]            o_data,
  output logic                              o_data_vld,
  input  logic                              i_data_rdy,
  output logic [$clog2(NUM_KERNEL)-1:0]     o_kernel_idx,
  output logic                              o_last,
  output logic                              o_full,
  output logic [REG_WIDTH-1:0]              err_psum
);

  localparam int PW = psum_width(BIT_WIDTH);
  localparam int EW = PW * NUM_KERNEL;
  localparam int KW = $clog2(NUM_KERNEL);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [EW-1:0]        w_fifo_dat;
  logic [EW-1:0]        w_head;
  logic [CW-1:0]        w_count;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push_req;
  logic                 w_mismatch;
  logic                 w_drop;
  logic                 w_pop;
  logic                 w_hs;
  logic                 w_last_beat;
  logic                 w_adv;
  logic                 w_finish;
  state_e               r_state;
  state_e               w_state_nxt;
  logic [EW-1:0]        r_shift;
  logic [KW-1:0]        r_beat;
  logic                 r_data_vld;
  logic [REG_WIDTH-1:0] r_err;

  // Only a complete set of lanes is an entry; a partial set is a PE-side fault.
  assign w_push_req = &i_psum_vld;
  assign w_mismatch = (i_psum_vld != '0) && !w_push_req;
  assign w_drop     = w_push_req && w_full && !w_pop;

  psum_sync_fifo #(
    .W  (EW),
    .D  (FIFO_DEPTH),
    .CW (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push_req),
    .i_pop   (w_pop),
    .i_dat   (i_psum),
    .o_dat   (w_fifo_dat),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Optional clamp of negative lanes as they leave the FIFO, so it costs no cycle.
  always_comb begin
    w_head = w_fifo_dat;
`ifdef PSUM_RELU_EN
    for (int k = 0; k < NUM_KERNEL; k++) begin
      if (w_fifo_dat[PW*(k+1)-1]) w_head[PW*k +: PW] = '0;
    end
`endif
  end

  assign w_hs        = r_data_vld && i_data_rdy;
  assign w_last_beat = (r_beat == KW'(NUM_KERNEL - 1));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state and datapath strobes; the last beat reloads directly so entries leave back to back.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_adv       = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (w_hs) begin
          if (!w_last_beat) begin
            w_adv = 1'b1;
          end else if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_finish    = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output shift register: lane 0 sits in the low bits and the entry shifts down one lane per beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shift    <= '0;
      r_beat     <= '0;
      r_data_vld <= 1'b0;
    end else if (w_pop) begin
      r_shift    <= w_head;
      r_beat     <= '0;
      r_data_vld <= 1'b1;
    end else if (w_adv) begin
      r_shift    <= r_shift >> PW;
      r_beat     <= r_beat + KW'(1);
    end else if (w_finish) begin
      r_data_vld <= 1'b0;
    end
  end

  // Sticky error flags and saturating drop counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_err <= '0;
    end else begin
      if (w_mismatch) r_err[ERR_VLD_MISMATCH] <= 1'b1;
      if (w_pop && (w_count == '0)) r_err[ERR_UNDERFLOW] <= 1'b1;
      if (w_drop) begin
        r_err[ERR_OVERFLOW] <= 1'b1;
        if (r_err[ERR_DROP_LSB +: DROP_CNT_WIDTH] != {DROP_CNT_WIDTH{1'b1}})
          r_err[ERR_DROP_LSB +: DROP_CNT_WIDTH] <= r_err[ERR_DROP_LSB +: DROP_CNT_WIDTH] + DROP_CNT_WIDTH'(1);
      end
    end
  end

  assign o_data       = r_shift[PW-1:0];
  assign o_data_vld   = r_data_vld;
  assign o_kernel_idx = r_beat;
  assign o_last       = r_data_vld && w_last_beat;
  assign o_full       = w_full;
  assign err_psum     = r_err;

endmodule

// File: tb/tb_kernel_psum_collector.sv
// Bench for kernel_psum_collector: directed phases plus random traffic against a queue-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_kernel_psum_collector;

  localparam int PW = 16;
  localparam int NK = 4;
  localparam int D  = 16;

  logic          clk;
  logic          rst;
  logic [63:0]   i_psum;
  logic [3:0]    i_psum_vld;
  logic [15:0]   o_data;
  logic          o_data_vld;
  logic          i_data_rdy;
  logic [1:0]    o_kernel_idx;
  logic          o_last;
  logic          o_full;
  logic [31:0]   err_psum;

  kernel_psum_collector #(
    .BIT_WIDTH  (8),
    .NUM_KERNEL (NK),
    .FIFO_DEPTH (D),
    .REG_WIDTH  (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_psum       (i_psum),
    .i_psum_vld   (i_psum_vld),
    .o_data       (o_data),
    .o_data_vld   (o_data_vld),
    .i_data_rdy   (i_data_rdy),
    .o_kernel_idx (o_kernel_idx),
    .o_last       (o_last),
    .o_full       (o_full),
    .err_psum     (err_psum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_beats = 0;

  // Reference model: the FIFO as a queue of whole entries, plus the entry being sent.
  logic [63:0] m_q[$];
  logic [63:0] m_cur;
  int          m_beat;
  bit          m_inflight;
  bit          m_err0;
  bit          m_err1;
  int          m_drop;

  function automatic logic [15:0] exp_lane(input logic [63:0] e, input int k);
    logic [15:0] v;
    v = e[k*PW +: PW];
`ifdef PSUM_RELU_EN
    if (v[15]) v = 16'h0000;
`endif
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs at the falling edge, compare outputs against the model, advance the model.
  task automatic cyc(input logic [3:0] vld, input logic [63:0] ps, input logic rdy, input logic rstv);
    bit hs, pop, push_req, accept;
    logic [31:0] exp_err;
    @(negedge clk);
    rst        = rstv;
    i_psum_vld = vld;
    i_psum     = ps;
    i_data_rdy = rdy;
    exp_err = {m_drop[15:0], 13'd0, 1'b0, m_err1, m_err0};
    check("vld", o_data_vld, m_inflight);
    if (m_inflight) begin
      check("data", o_data, exp_lane(m_cur, m_beat));
      check("idx", o_kernel_idx, m_beat[1:0]);
      check("last", o_last, (m_beat == NK-1));
    end
    check("full", o_full, (m_q.size() == D));
    check("err", err_psum, exp_err);
    if (o_data_vld && rdy) n_beats++;
    if (!rstv) begin
      m_q.delete();
      m_inflight = 0;
      m_beat     = 0;
      m_err0     = 0;
      m_err1     = 0;
      m_drop     = 0;
    end else begin
      hs       = m_inflight && rdy;
      pop      = (m_q.size() > 0) && (!m_inflight || (hs && m_beat == NK-1));
      push_req = (vld == 4'hF);
      accept   = push_req && ((m_q.size() < D) || pop);
      if (vld != 4'h0 && !push_req) m_err0 = 1;
      if (push_req && !accept) begin
        m_err1 = 1;
        if (m_drop < 65535) m_drop++;
      end
      if (pop) begin
        m_cur      = m_q.pop_front();
        m_beat     = 0;
        m_inflight = 1;
      end else if (hs) begin
        if (m_beat == NK-1) m_inflight = 0;
        else m_beat++;
      end
      if (accept) m_q.push_back(ps);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int b0;
    logic [3:0] v;
    logic       r;
    rst = 1'b0; i_psum = '0; i_psum_vld = '0; i_data_rdy = 1'b0;
    m_q.delete(); m_cur = '0; m_beat = 0; m_inflight = 0;
    m_err0 = 0; m_err1 = 0; m_drop = 0;

    // Reset state
    repeat (3) cyc(4'h0, 64'h0, 1'b1, 1'b0);
    cyc(4'h0, 64'h0, 1'b1, 1'b1);
    check("rst_data", o_data, 16'h0);
    check("rst_vld", o_data_vld, 1'b0);
    check("rst_idx", o_kernel_idx, 2'd0);
    check("rst_last", o_last, 1'b0);
    check("rst_full", o_full, 1'b0);
    check("rst_err", err_psum, 32'h0);

    // Single entry: beats 1,2,3,4 two cycles after the push
    cyc(4'hF, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 1'b1, 1'b1);
    cyc(4'h0, 64'h0, 1'b1, 1'b1);
    check("lat_t1_vld", o_data_vld, 1'b0);
    cyc(4'h0, 64'h0, 1'b1, 1'b1);
    check("lat_t2_vld", o_data_vld, 1'b1);
    check("lat_t2_data", o_data, 16'h0001);
    repeat (5) cyc(4'h0, 64'h0, 1'b1, 1'b1);
    check("single_beats", n_beats, 4);

    // Back-pressure: three pushes, rdy pattern 1,0,0,1
    b0 = n_beats;
    for (int i = 0; i < 3; i++) cyc(4'hF, rnd64(), 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) cyc(4'h0, 64'h0, (i % 4 == 0) || (i % 4 == 3), 1'b1);
    check("bp_beats", n_beats - b0, 12);

    // Overflow: 20 pushes with rdy low
    b0 = n_beats;
    for (int i = 0; i < 20; i++) cyc(4'hF, rnd64(), 1'b0, 1'b1);
    cyc(4'h0, 64'h0, 1'b0, 1'b1);
    check("ovf_full", o_full, 1'b1);
    check("ovf_bit", err_psum[1], 1'b1);
    check("ovf_drops", err_psum[31:16], 16'd3);
    for (int i = 0; i < 80; i++) cyc(4'h0, 64'h0, 1'b1, 1'b1);
    check("ovf_drain_beats", n_beats - b0, 68);

    // Full FIFO with a push landing on the pop cycle
    for (int i = 0; i < 17; i++) cyc(4'hF, rnd64(), 1'b0, 1'b1);
    cyc(4'h0, 64'h0, 1'b0, 1'b1);
    check("fp_full", o_full, 1'b1);
    for (int i = 0; i < 3; i++) cyc(4'h0, 64'h0, 1'b1, 1'b1);
    cyc(4'hF, rnd64(), 1'b1, 1'b1);
    cyc(4'h0, 64'h0, 1'b0, 1'b1);
    check("fp_full_after", o_full, 1'b1);
    check("fp_drops", err_psum[31:16], 16'd3);
    for (int i = 0; i < 80; i++) cyc(4'h0, 64'h0, 1'b1, 1'b1);

    // Malformed valid pattern
    b0 = n_beats;
    cyc(4'b0111, rnd64(), 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cyc(4'h0, 64'h0, 1'b1, 1'b1);
    check("mal_bit", err_psum[0], 1'b1);
    check("mal_beats", n_beats - b0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: v = 4'hF;
        4:          v = 4'($urandom_range(1, 14));
        default:    v = 4'h0;
      endcase
      r = ($urandom_range(0, 3) != 0);
      cyc(v, rnd64(), r, 1'b1);
    end
    for (int i = 0; i < 80; i++) cyc(4'h0, 64'h0, 1'b1, 1'b1);
    check("rand_mal_sticky", err_psum[0], 1'b1);

    // Reset during SEND after beat 1
    cyc(4'h0, 64'h0, 1'b1, 1'b0);
    cyc(4'hF, {16'hFFF0, 16'h0033, 16'h0022, 16'h0011}, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(4'h0, 64'h0, 1'b1, 1'b1);
    cyc(4'h0, 64'h0, 1'b1, 1'b0);
    cyc(4'h0, 64'h0, 1'b1, 1'b1);
    check("rstmid_vld", o_data_vld, 1'b0);
    check("rstmid_err", err_psum, 32'h0);
    b0 = n_beats;
    for (int i = 0; i < 10; i++) cyc(4'h0, 64'h0, 1'b1, 1'b1);
    check("rstmid_no_stale", n_beats - b0, 0);

    // Negative and boundary lanes
    cyc(4'hF, {16'hFFF0, 16'h7FFF, 16'h8000, 16'h0005}, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) cyc(4'h0, 64'h0, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
